// File: rtl/alu_frame_ctrl_pkg.sv
// Shared definitions for the byte-serial ALU frame controller: ALU opcodes,
// controller states, frame lengths and the divide-by-zero response.
package alu_frame_ctrl_pkg;

  typedef enum logic [3:0] {
    FUN_ADD    = 4'b0000,
    FUN_SUB    = 4'b0001,
    FUN_MUL    = 4'b0010,
    FUN_DIV    = 4'b0011,
    FUN_AND    = 4'b0100,
    FUN_OR     = 4'b0101,
    FUN_NAND   = 4'b0110,
    FUN_NOR    = 4'b0111,
    FUN_XOR    = 4'b1000,
    FUN_XNOR   = 4'b1001,
    FUN_CMP_EQ = 4'b1010,
    FUN_CMP_GT = 4'b1011,
    FUN_CMP_LT = 4'b1100,
    FUN_SHR    = 4'b1101,
    FUN_SHL    = 4'b1110,
    FUN_NOP    = 4'b1111
  } alu_fun_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_A_LO,
    ST_GET_A_HI,
    ST_GET_B_LO,
    ST_GET_B_HI,
    ST_EXEC,
    ST_CAPTURE,
    ST_SEND_LO,
    ST_SEND_HI,
    ST_SEND_FLG
  } state_e;

  localparam logic [2:0]  FRAME_LEN_FULL  = 3'd5;
  localparam logic [2:0]  FRAME_LEN_SHIFT = 3'd3;
  localparam logic [15:0] DIV_ZERO_RESULT = 16'hFFFF;
  localparam logic [3:0]  DIV_ZERO_FLAGS  = 4'b0001;

  function automatic logic is_shift_fun(input logic [3:0] fun);
    return (fun == FUN_SHR) || (fun == FUN_SHL);
  endfunction

  // Shift frames carry no B operand, so they end after the A_hi byte.
  function automatic logic [2:0] frame_len(input logic [3:0] fun);
    return is_shift_fun(fun) ? FRAME_LEN_SHIFT : FRAME_LEN_FULL;
  endfunction

endpackage

// File: rtl/alu_frame_ctrl_timeout.sv
// Inter-byte idle counter: counts enabled cycles without a clear and pulses
// o_expire on the TIMEOUT_CYCLES-th one. TIMEOUT_CYCLES = 0 disables it.
module alu_frame_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      logic w_unused_inputs;
      assign w_unused_inputs = ^{clk, rst, i_enable, i_clear};
      assign o_expire        = 1'b0;
    end else begin : g_enabled
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

      logic [CW-1:0] r_count;

      assign o_expire = i_enable && !i_clear && (r_count == CW'(TIMEOUT_CYCLES - 1));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_count <= '0;
        end else if (!i_enable || i_clear || o_expire) begin
          r_count <= '0;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/alu_frame_ctrl.sv
// Byte-stream front end for the 16-bit registered ALU: assembles command frames,
// drives the ALU and streams the result back. ALU_FRAME_CTRL_FLAGS_EN adds a flags byte.
module alu_frame_ctrl
  import alu_frame_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_fun,
  input  logic [15:0] alu_out,
  input  logic        alu_arith_flag,
  input  logic        alu_logic_flag,
  input  logic        alu_cmp_flag,
  input  logic        alu_shift_flag,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        err
);

  state_e      r_state;
  logic        r_ready_en;
  logic [3:0]  r_fun;
  logic [7:0]  r_a_lo;
  logic [7:0]  r_a_hi;
  logic [7:0]  r_b_lo;
  logic [2:0]  r_byte_cnt;
  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [3:0]  r_alu_fun;
  logic [15:0] r_result;
  logic [3:0]  r_flags;
  logic        r_err;

  logic        w_accepting;
  logic        w_in_get;
  logic        w_xfer;
  logic        w_last_byte;
  logic        w_div_zero;
  logic        w_timeout;

  assign w_accepting = (r_state == ST_IDLE)     || (r_state == ST_GET_A_LO) ||
                       (r_state == ST_GET_A_HI) || (r_state == ST_GET_B_LO) ||
                       (r_state == ST_GET_B_HI);
  assign w_in_get    = w_accepting && (r_state != ST_IDLE);

  // r_ready_en keeps in_ready low while reset is held and until the first edge after it.
  assign in_ready    = r_ready_en && w_accepting;
  assign w_xfer      = in_valid && in_ready;
  assign w_last_byte = (r_byte_cnt == frame_len(r_fun) - 3'd1);
  assign w_div_zero  = (r_fun == FUN_DIV) && ({in_data, r_b_lo} == 16'd0);

  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_fun = r_alu_fun;
  assign busy    = (r_state != ST_IDLE);
  assign err     = r_err;

  alu_frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_enable (w_in_get),
    .i_clear  (w_xfer),
    .o_expire (w_timeout)
  );

  // The ALU operand registers only load on the way into EXEC, so they stay frozen
  // through CAPTURE, SEND and any aborted or divide-by-zero frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ready_en <= 1'b0;
      r_fun      <= 4'd0;
      r_a_lo     <= 8'd0;
      r_a_hi     <= 8'd0;
      r_b_lo     <= 8'd0;
      r_byte_cnt <= 3'd0;
      r_alu_a    <= 16'd0;
      r_alu_b    <= 16'd0;
      r_alu_fun  <= FUN_ADD;
      r_result   <= 16'd0;
      r_flags    <= 4'd0;
      r_err      <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      r_err      <= 1'b0;
      if (w_timeout) begin
        r_state    <= ST_IDLE;
        r_err      <= 1'b1;
        r_byte_cnt <= 3'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_xfer) begin
              r_fun      <= in_data[3:0];
              r_byte_cnt <= 3'd1;
              r_state    <= ST_GET_A_LO;
            end
          end
          ST_GET_A_LO: begin
            if (w_xfer) begin
              r_a_lo     <= in_data;
              r_byte_cnt <= r_byte_cnt + 3'd1;
              r_state    <= ST_GET_A_HI;
            end
          end
          ST_GET_A_HI: begin
            if (w_xfer) begin
              r_a_hi     <= in_data;
              r_byte_cnt <= r_byte_cnt + 3'd1;
              if (w_last_byte) begin
                r_alu_a   <= {in_data, r_a_lo};
                r_alu_b   <= 16'd0;
                r_alu_fun <= r_fun;
                r_state   <= ST_EXEC;
              end else begin
                r_state   <= ST_GET_B_LO;
              end
            end
          end
          ST_GET_B_LO: begin
            if (w_xfer) begin
              r_b_lo     <= in_data;
              r_byte_cnt <= r_byte_cnt + 3'd1;
              r_state    <= ST_GET_B_HI;
            end
          end
          ST_GET_B_HI: begin
            if (w_xfer) begin
              r_byte_cnt <= r_byte_cnt + 3'd1;
              if (w_div_zero) begin
                r_result <= DIV_ZERO_RESULT;
                r_flags  <= DIV_ZERO_FLAGS;
                r_err    <= 1'b1;
                r_state  <= ST_SEND_LO;
              end else begin
                r_alu_a   <= {r_a_hi, r_a_lo};
                r_alu_b   <= {in_data, r_b_lo};
                r_alu_fun <= r_fun;
                r_state   <= ST_EXEC;
              end
            end
          end
          ST_EXEC: begin
            r_state <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            r_result <= alu_out;
            r_flags  <= {alu_shift_flag, alu_cmp_flag, alu_logic_flag, alu_arith_flag};
            r_state  <= ST_SEND_LO;
          end
          ST_SEND_LO: begin
            if (out_ready) begin
              r_state <= ST_SEND_HI;
            end
          end
          ST_SEND_HI: begin
            if (out_ready) begin
`ifdef ALU_FRAME_CTRL_FLAGS_EN
              r_state <= ST_SEND_FLG;
`else
              r_state <= ST_IDLE;
`endif
            end
          end
`ifdef ALU_FRAME_CTRL_FLAGS_EN
          ST_SEND_FLG: begin
            if (out_ready) begin
              r_state <= ST_IDLE;
            end
          end
`endif
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Response bytes are decoded from the state and result registers only, so they
  // hold steady under backpressure and drop as soon as reset forces IDLE.
  always_comb begin
    out_data  = 8'h00;
    out_valid = 1'b0;
    case (r_state)
      ST_SEND_LO: begin
        out_data  = r_result[7:0];
        out_valid = 1'b1;
      end
      ST_SEND_HI: begin
        out_data  = r_result[15:8];
        out_valid = 1'b1;
      end
`ifdef ALU_FRAME_CTRL_FLAGS_EN
      ST_SEND_FLG: begin
        out_data  = {4'b0000, r_flags};
        out_valid = 1'b1;
      end
`endif
      default: begin
        out_data  = 8'h00;
        out_valid = 1'b0;
      end
    endcase
  end

`ifndef ALU_FRAME_CTRL_FLAGS_EN
  logic w_unused_flags;
  assign w_unused_flags = ^r_flags;
`endif

endmodule
